// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the RAM built-in self-test sequencer.
package ram_bist_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4,
      FAIL  = 3'd5
   } state_e;

   // Per-pass XOR masks; callers slice down to their data width
   localparam int unsigned PAT_MAX_W = 64;
   localparam logic [PAT_MAX_W-1:0] PAT_XOR_P0 = '0;
   localparam logic [PAT_MAX_W-1:0] PAT_XOR_P1 = '1;

endpackage

// File: rtl/ram_bist_ctrl_lock_qual.sv
// PLL lock qualifier: 2-flop synchronizer followed by a saturating
// stability counter; lock_ok_o asserts once lock has been stable LOCK_WAIT cycles.
module lock_qual #(
   parameter int unsigned LOCK_WAIT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic locked_i,
   output logic lock_s_o,
   output logic lock_ok_o
);

   localparam int unsigned CNT_W = $clog2(LOCK_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_WAIT);

   logic             meta_q;
   logic             sync_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             ok_q;
   logic             ok_d;

   // Count while synchronized lock is high, saturate, clear on loss
   always_comb begin
      cnt_d = cnt_q;
      if (!sync_q) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      ok_d = (cnt_d == CNT_MAX);
   end

   // Synchronizer, counter and registered qualification flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         cnt_q  <= '0;
         ok_q   <= 1'b0;
      end else begin
         meta_q <= locked_i;
         sync_q <= meta_q;
         cnt_q  <= cnt_d;
         ok_q   <= ok_d;
      end
   end

   assign lock_s_o  = sync_q;
   assign lock_ok_o = ok_q;

endmodule

// File: rtl/ram_bist_ctrl.sv
// RAM BIST sequencer: waits for qualified PLL lock, then runs two
// write/read-back passes (address pattern, then its inverse) and
// reports pass/fail on sticky flags and the status LEDs.
module ram_bist_ctrl
   import ram_bist_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned LOCK_WAIT = 1024,
   parameter int unsigned HB_W      = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              locked,
   input  logic              restart,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              done,
   output logic              fail,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [7:0]        led_o
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              p_q, p_d;
   logic              vld_q, vld_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic [ADDR_W-1:0] faddr_q, faddr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              done_q, done_d;
   logic              fail_q, fail_d;
   logic              busy_q, busy_d;
   logic [HB_W-1:0]   hb_q, hb_d;

   logic              lock_s;
   logic              lock_ok;
   logic              rd_mismatch;
   logic              addr_last;
   logic [ADDR_W-1:0] addr_inc;

   // Expected data for address a in pass p
   function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic p);
      logic [DATA_W-1:0] mask;
      mask = p ? PAT_XOR_P1[DATA_W-1:0] : PAT_XOR_P0[DATA_W-1:0];
      return DATA_W'(a) ^ mask;
   endfunction

   lock_qual #(
      .LOCK_WAIT (LOCK_WAIT)
   ) u_lock_qual (
      .clk       (clk),
      .rst_n     (rst_n),
      .locked_i  (locked),
      .lock_s_o  (lock_s),
      .lock_ok_o (lock_ok)
   );

   // Next-state, address/pass sequencing, read compare and registered-output decode
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      p_d       = p_q;
      vld_d     = 1'b0;
      raddr_d   = addr_q;
      faddr_d   = faddr_q;
      hb_d      = hb_q + HB_W'(1);

      addr_inc    = addr_q + ADDR_W'(1);
      addr_last   = (addr_q == {ADDR_W{1'b1}});
      rd_mismatch = vld_q && (ram_rdata != pat(raddr_q, p_q));

      unique case (state_q)
         IDLE: begin
            addr_d = '0;
            p_d    = 1'b0;
            if (lock_ok) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (!lock_s) begin
               state_d = IDLE;
               addr_d  = '0;
               p_d     = 1'b0;
            end else begin
               addr_d = addr_inc;
               if (addr_last) begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            if (!lock_s) begin
               state_d = IDLE;
               addr_d  = '0;
               p_d     = 1'b0;
            end else if (rd_mismatch) begin
               state_d = FAIL;
               faddr_d = raddr_q;
            end else begin
               addr_d = addr_inc;
               vld_d  = 1'b1;
               if (addr_last) begin
                  state_d = CHECK;
               end
            end
         end
         CHECK: begin
            if (!lock_s) begin
               state_d = IDLE;
               addr_d  = '0;
               p_d     = 1'b0;
            end else if (rd_mismatch) begin
               state_d = FAIL;
               faddr_d = raddr_q;
            end else if (!p_q) begin
               state_d = WRITE;
               addr_d  = '0;
               p_d     = 1'b1;
            end else begin
               state_d = DONE;
            end
         end
         DONE, FAIL: begin
            if (restart) begin
               state_d = IDLE;
               addr_d  = '0;
               p_d     = 1'b0;
               faddr_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      we_d    = (state_d == WRITE);
      wdata_d = we_d ? pat(addr_d, p_d) : '0;
      done_d  = (state_d == DONE);
      fail_d  = (state_d == FAIL);
      busy_d  = (state_d == WRITE) || (state_d == READ) || (state_d == CHECK);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         p_q     <= 1'b0;
         vld_q   <= 1'b0;
         raddr_q <= '0;
         faddr_q <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         fail_q  <= 1'b0;
         busy_q  <= 1'b0;
         hb_q    <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         p_q     <= p_d;
         vld_q   <= vld_d;
         raddr_q <= raddr_d;
         faddr_q <= faddr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         fail_q  <= fail_d;
         busy_q  <= busy_d;
         hb_q    <= hb_d;
      end
   end

   assign ram_we    = we_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign done      = done_q;
   assign fail      = fail_q;
   assign fail_addr = faddr_q;
   assign led_o     = {hb_q[HB_W-1], hb_q[HB_W-2], 1'b0, p_q, fail_q, done_q, busy_q, lock_ok};

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl with a behavioural 16x8 synchronous RAM,
// fault injection on the write path and a write-transaction scoreboard.
module tb_ram_bist_ctrl;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 8;

   logic          clk;
   logic          rst_n;
   logic          locked;
   logic          restart;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
   logic          done;
   logic          fail;
   logic [AW-1:0] fail_addr;
   logic [7:0]    led_o;

   ram_bist_ctrl #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .LOCK_WAIT (8),
      .HB_W      (24)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .locked    (locked),
      .restart   (restart),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .done      (done),
      .fail      (fail),
      .fail_addr (fail_addr),
      .led_o     (led_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM; fault 1 = addr 5 bit 0 stuck at 0, fault 2 = addr F drops 0xF0 to 0x00
   logic [DW-1:0] mem [16];
   logic [1:0]    fault;
   logic [DW-1:0] wval;

   always_comb begin
      wval = ram_wdata;
      if (fault == 2'd1 && ram_addr == 4'd5) wval[0] = 1'b0;
      if (fault == 2'd2 && ram_addr == 4'hF && ram_wdata == 8'hF0) wval = 8'h00;
   end

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= wval;
      ram_rdata <= mem[ram_addr];
   end

   // Scoreboard of expected RAM writes
   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;
   wr_t sb_q [$];

   typedef struct {
      logic [1:0]    mode;
      int            term;
      logic          exp_done;
      logic          exp_fail;
      logic [AW-1:0] faddr;
      logic          chk_p;
      logic          p;
      int            writes;
   } vec_t;
   vec_t vec [3];

   int n_chk;
   int n_pass;
   int edge_n;
   int n_wr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
   endtask

   task automatic push_run();
      wr_t e;
      sb_q.delete();
      for (int p = 0; p < 2; p++) begin
         for (int a = 0; a < 16; a++) begin
            e.addr = 4'(a);
            e.data = (p == 1) ? ~{4'h0, 4'(a)} : {4'h0, 4'(a)};
            sb_q.push_back(e);
         end
      end
   endtask

   // One clock, sampled 1 time unit after the edge; pops the scoreboard on writes
   task automatic tick();
      wr_t e;
      @(posedge clk);
      #1;
      edge_n++;
      if (ram_we === 1'b1) begin
         n_wr++;
         if (sb_q.size() == 0) begin
            n_chk++;
            $display("FAIL write_op: unexpected write addr %0h data %0h (edge %0d)", ram_addr, ram_wdata, edge_n);
         end else begin
            e = sb_q.pop_front();
            check("write_op", 32'({ram_addr, ram_wdata}), 32'({e.addr, e.data}));
         end
      end
   endtask

   function automatic logic cond(input int which);
      case (which)
         0:       return led_o[0];
         1:       return ram_we;
         default: return done | fail;
      endcase
   endfunction

   // Tick until condition holds; returns edge index, or -1 with a FAIL line on timeout
   task automatic wait_cond(input int which, input int max, input string name, output int at);
      at = -1;
      for (int k = 0; k < max; k++) begin
         tick();
         if (cond(which) === 1'b1) begin
            at = edge_n;
            return;
         end
      end
      n_chk++;
      $display("FAIL %s: timeout after %0d cycles, required condition %0d", name, max, which);
   endtask

   task automatic check_zero(input string name);
      check({name, "_ctl"}, 32'({ram_we, done, fail}), 32'd0);
      check({name, "_bus"}, 32'({ram_addr, fail_addr, ram_wdata}), 32'd0);
      check({name, "_led"}, 32'(led_o), 32'd0);
   endtask

   // Assert reset, check reset state, release with lock raised and a fresh scoreboard
   task automatic do_reset(input logic [1:0] mode);
      rst_n   = 1'b0;
      locked  = 1'b0;
      restart = 1'b0;
      #1;
      check_zero("reset");
      tick();
      tick();
      fault  = mode;
      n_wr   = 0;
      rst_n  = 1'b1;
      locked = 1'b1;
      edge_n = 0;
      push_run();
   endtask

   initial begin
      int at;
      n_chk   = 0;
      n_pass  = 0;
      edge_n  = 0;
      n_wr    = 0;
      fault   = 2'd0;
      rst_n   = 1'b0;
      locked  = 1'b0;
      restart = 1'b0;

      vec[0] = '{2'd0, 77, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 32};
      vec[1] = '{2'd1, 34, 1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 16};
      vec[2] = '{2'd2, 77, 1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 32};

      // Table-driven full runs: clean, pass-0 stuck bit, pass-1-only fault
      for (int i = 0; i < 3; i++) begin
         do_reset(vec[i].mode);
         wait_cond(0, 40, "lock_wait", at);
         check("lock_ok_cycle", 32'(at), 32'd10);
         wait_cond(1, 10, "write_wait", at);
         check("write_start", 32'(at), 32'd11);
         wait_cond(2, 200, "term_wait", at);
         check("term_cycle", 32'(at), 32'(vec[i].term));
         check("done", 32'({done, led_o[2]}), 32'({vec[i].exp_done, vec[i].exp_done}));
         check("fail", 32'({fail, led_o[3]}), 32'({vec[i].exp_fail, vec[i].exp_fail}));
         check("fail_addr", 32'(fail_addr), 32'(vec[i].faddr));
         if (vec[i].chk_p) check("led_p", 32'(led_o[4]), 32'(vec[i].p));
         repeat (20) tick();
         check("write_count", 32'(n_wr), 32'(vec[i].writes));
         check("idle_after", 32'({led_o[1], ram_we, done, fail}),
               32'({1'b0, 1'b0, vec[i].exp_done, vec[i].exp_fail}));
      end

      // Lock glitch in the middle of the pass-0 read phase
      do_reset(2'd0);
      wait_cond(1, 40, "glitch_write_wait", at);
      while (edge_n < 35) tick();
      check("glitch_in_read", 32'({led_o[1], ram_we, led_o[4]}), 32'({1'b1, 1'b0, 1'b0}));
      locked = 1'b0;
      repeat (3) tick();
      locked = 1'b1;
      check("glitch_idle", 32'({led_o[1], ram_we, led_o[0], led_o[4]}), 32'd0);
      push_run();
      wait_cond(1, 40, "glitch_rewrite_wait", at);
      check("glitch_restart_addr0", 32'({ram_addr, ram_wdata, led_o[4]}), 32'd0);
      wait_cond(2, 100, "glitch_done_wait", at);
      check("glitch_done", 32'({done, fail}), 32'({1'b1, 1'b0}));

      // Restart from DONE; a restart pulse during WRITE is ignored
      restart = 1'b1;
      tick();
      restart = 1'b0;
      check("restart_clears", 32'({done, led_o[2], fail}), 32'd0);
      edge_n = 0;
      push_run();
      wait_cond(1, 5, "restart_write_wait", at);
      check("restart_write_start", 32'(at), 32'd1);
      repeat (5) tick();
      restart = 1'b1;
      tick();
      restart = 1'b0;
      check("restart_in_write", 32'({ram_we, led_o[1]}), 32'({1'b1, 1'b1}));
      wait_cond(2, 100, "restart_done_wait", at);
      check("restart_done_cycle", 32'(at), 32'd67);
      check("restart_done", 32'({done, fail}), 32'({1'b1, 1'b0}));

      // Asynchronous reset in the middle of WRITE
      do_reset(2'd0);
      wait_cond(1, 40, "arst_write_wait", at);
      repeat (4) tick();
      #3;
      rst_n = 1'b0;
      #1;
      check_zero("arst");
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      edge_n = 0;
      n_wr   = 0;
      push_run();
      wait_cond(0, 40, "arst_lock_wait", at);
      check("arst_lock_cycle", 32'(at), 32'd10);
      wait_cond(2, 100, "arst_done_wait", at);
      check("arst_done", 32'({done, fail}), 32'({1'b1, 1'b0}));
      check("arst_writes", 32'(n_wr), 32'd32);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
